// File: rtl/tick_timer_pkg.sv
// ---------------------------------------------------------------------------
// tick_timer_pkg
// Shared types for the multi-channel tick timer.
//   mode_t        : channel mode (periodic / one-shot)
//   chan_state_t  : channel FSM state (idle / running)
//   min1_clog2()  : index width helper that never returns 0
// ---------------------------------------------------------------------------
package tick_timer_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    // Width needed to index n items, at least one bit so a single
    // channel or a divide-by-1 prescaler still has a legal vector.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_timer_chan.sv
// ---------------------------------------------------------------------------
// tick_timer_chan
// One timer channel: holds its programmed period and mode, counts base
// strobes while running and emits a registered one-cycle tick when the
// count reaches period-1.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cfg_we       : latch cfg_period / cfg_mode this edge
//   cfg_period   : period in base strobes
//   cfg_mode     : 0 = periodic, 1 = one-shot
//   start, stop  : start/retrigger and stop requests (stop has priority)
//   strobe       : shared prescaler strobe
//   tick         : one-cycle tick pulse (registered)
//   active       : channel is running
//   count        : current strobe count
// ---------------------------------------------------------------------------
module tick_timer_chan
    import tick_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             strobe,
    output logic             tick,
    output logic             active,
    output logic [WIDTH-1:0] count
);

    chan_state_t      state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             tick_reg, tick_next;
    logic [WIDTH-1:0] period_reg;
    mode_t            mode_reg;

    // A start on the same edge as a config write must see the new period.
    logic [WIDTH-1:0] eff_period;
    logic [WIDTH-1:0] last_count;

    assign eff_period = cfg_we ? cfg_period : period_reg;
    // Only evaluated while running, and a channel never runs with period 0,
    // so the subtraction cannot wrap in a way that matters.
    assign last_count = period_reg - WIDTH'(1);

    // Configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_reg <= '0;
            mode_reg   <= MODE_PERIODIC;
        end else if (cfg_we) begin
            period_reg <= cfg_period;
            mode_reg   <= mode_t'(cfg_mode);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            tick_reg  <= tick_next;
        end
    end

    // Next-state logic: stop > start > strobe
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tick_next  = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else if (start && (eff_period != '0)) begin
            state_next = ST_RUN;
            count_next = '0;
        end else if ((state_reg == ST_RUN) && strobe) begin
            if (count_reg == last_count) begin
                tick_next  = 1'b1;
                count_next = '0;
                if (mode_reg == MODE_ONESHOT) begin
                    state_next = ST_IDLE;
                end
            end else begin
                count_next = count_reg + WIDTH'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        active = (state_reg == ST_RUN);
        tick   = tick_reg;
        count  = count_reg;
    end

endmodule

// File: rtl/tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
// Multi-channel programmable tick generator. A free-running prescaler makes
// a base strobe every PRESCALE cycles; each of NCH channels divides that
// strobe by its own programmed period, periodic or one-shot.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_cfg_valid    : config write request
//   o_cfg_ready    : selected channel exists and is idle (combinational)
//   i_cfg_ch       : config target channel
//   i_cfg_period   : period in base strobes
//   i_cfg_mode     : 0 = periodic, 1 = one-shot
//   i_start        : per-channel start / retrigger
//   i_stop         : per-channel stop
//   o_tick         : per-channel one-cycle tick (registered)
//   o_active       : per-channel running flag
//   o_count        : channel c count at [c*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter  int NCH      = 4,
    parameter  int WIDTH    = 16,
    parameter  int PRESCALE = 1,
    localparam int CH_W     = min1_clog2(NCH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [CH_W-1:0]      i_cfg_ch,
    input  logic [WIDTH-1:0]     i_cfg_period,
    input  logic                 i_cfg_mode,
    input  logic [NCH-1:0]       i_start,
    input  logic [NCH-1:0]       i_stop,
    output logic [NCH-1:0]       o_tick,
    output logic [NCH-1:0]       o_active,
    output logic [NCH*WIDTH-1:0] o_count
);

    localparam int              PS_W    = min1_clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] presc_reg, presc_next;
    logic            strobe;

    // Free-running prescaler; start/stop/config never touch it, so the
    // first tick after a start depends on the current phase.
    assign strobe     = (presc_reg == PS_LAST);
    assign presc_next = strobe ? '0 : presc_reg + PS_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    // Ready only for an existing, idle channel. Out-of-range channel numbers
    // match no iteration and therefore read as not ready.
    always_comb begin
        o_cfg_ready = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if ((i_cfg_ch == CH_W'(c)) && !o_active[c]) begin
                o_cfg_ready = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic cfg_we;

            assign cfg_we = i_cfg_valid && o_cfg_ready && (i_cfg_ch == CH_W'(gi));

            tick_timer_chan #(
                .WIDTH(WIDTH)
            ) u_chan (
                .clk        (i_clk),
                .rst_n      (i_rst_n),
                .cfg_we     (cfg_we),
                .cfg_period (i_cfg_period),
                .cfg_mode   (i_cfg_mode),
                .start      (i_start[gi]),
                .stop       (i_stop[gi]),
                .strobe     (strobe),
                .tick       (o_tick[gi]),
                .active     (o_active[gi]),
                .count      (o_count[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
